// File: rtl/pt2272_pkg.sv
// Shared types and frame geometry for the PT2272-style frame controller.
package pt2272_pkg;

   // Symbol codes produced by the upstream pulse-width classifier.
   typedef enum logic [1:0] {
      SYM_0    = 2'b00,
      SYM_SYNC = 2'b01,
      SYM_F    = 2'b10,
      SYM_1    = 2'b11
   } sym_code_t;

   // Frame parser states.
   typedef enum logic [2:0] {
      HUNT      = 3'd0,
      ADDR      = 3'd1,
      DATA      = 3'd2,
      SYNC_WAIT = 3'd3,
      CHECK     = 3'd4
   } state_t;

   localparam int unsigned ADDR_SYMS = 8;
   localparam int unsigned DATA_SYMS = 4;
   localparam int unsigned IDX_W     = 3;
   localparam int unsigned RUN_W     = 3;

endpackage

// File: rtl/pt2272_sym_watchdog.sv
// Idle-symbol watchdog: flags a frame as stalled after TIMEOUT cycles
// without a symbol strobe. A strobe in the expiry cycle wins and restarts it.
module pt2272_sym_watchdog
#(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic osc_clk,
   input  logic reset,
   input  logic enable,
   input  logic kick,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;

   // Expiry on the TIMEOUT-th consecutive idle cycle; count restarts on kick or when disabled.
   always_comb begin
      expired    = enable && !kick && (count_reg == CNT_LAST);
      count_next = count_reg + CNT_W'(1);
      if (!enable || kick || expired) begin
         count_next = '0;
      end
   end

   // Idle-cycle counter register.
   always_ff @(posedge osc_clk or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/pt2272_frame_controller.sv
// Frame controller: parses address/data/sync symbols, validates the local
// address, and publishes a data word after REPEAT_COUNT identical frames.
module pt2272_frame_controller
   import pt2272_pkg::*;
#(
   parameter int unsigned REPEAT_COUNT = 2,
   parameter int unsigned TIMEOUT      = 256
) (
   input  logic        osc_clk,
   input  logic        reset,
   input  logic        sym_valid,
   input  logic [1:0]  sym_code,
   input  logic [15:0] addr_code,
   output logic [3:0]  D,
   output logic        dv,
   output logic        err,
   output logic        busy
);

   localparam logic [IDX_W-1:0] ADDR_LAST = IDX_W'(ADDR_SYMS - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_SYMS - 1);
   localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(REPEAT_COUNT);
   localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);

   state_t             state_reg, state_next;
   logic [IDX_W-1:0]   idx_reg, idx_next;
   logic               mismatch_reg, mismatch_next;
   logic [RUN_W-1:0]   run_reg, run_next;
   logic [RUN_W-1:0]   run_inc;
   logic [3:0]         cand_reg, cand_next;
   logic [3:0]         data_reg, data_next;
   logic [3:0]         d_reg, d_next;
   logic               dv_reg, dv_next;
   logic               err_reg, err_next;

   logic               wd_expired;
   logic               is_sync;
   logic               is_body;
   logic [1:0]         addr_pair [ADDR_SYMS];

   // Split the trinary address into per-symbol code pairs.
   genvar gi;
   generate
      for (gi = 0; gi < ADDR_SYMS; gi++) begin : g_addr_pair
         assign addr_pair[gi] = addr_code[2*gi+1:2*gi];
      end
   endgenerate

   assign is_sync = sym_valid && (sym_code == SYM_SYNC);
   assign is_body = sym_valid && (sym_code != SYM_SYNC);
   assign run_inc = run_reg + RUN_ONE;

   pt2272_sym_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .osc_clk (osc_clk),
      .reset   (reset),
      .enable  (state_reg != HUNT),
      .kick    (sym_valid),
      .expired (wd_expired)
   );

   // Next-state, frame bookkeeping and output pulse decisions.
   always_comb begin
      state_next    = state_reg;
      idx_next      = idx_reg;
      mismatch_next = mismatch_reg;
      run_next      = run_reg;
      cand_next     = cand_reg;
      data_next     = data_reg;
      d_next        = d_reg;
      dv_next       = 1'b0;
      err_next      = 1'b0;

      if (wd_expired) begin
         // Stalled frame: abandon it and wait for a fresh sync.
         err_next      = 1'b1;
         run_next      = '0;
         idx_next      = '0;
         mismatch_next = 1'b0;
         state_next    = HUNT;
      end else begin
         case (state_reg)
            HUNT: begin
               if (is_sync) begin
                  state_next    = ADDR;
                  idx_next      = '0;
                  mismatch_next = 1'b0;
               end
            end

            ADDR, DATA: begin
               if (is_sync) begin
                  // A sync inside the body means the frame was truncated.
                  err_next      = 1'b1;
                  mismatch_next = 1'b0;
                  run_next      = '0;
                  idx_next      = '0;
                  state_next    = ADDR;
               end else if (is_body) begin
                  if (state_reg == ADDR) begin
                     if ((addr_pair[idx_reg] == SYM_SYNC) || (sym_code != addr_pair[idx_reg])) begin
                        mismatch_next = 1'b1;
                     end
                     if (idx_reg == ADDR_LAST) begin
                        idx_next   = '0;
                        state_next = DATA;
                     end else begin
                        idx_next = idx_reg + IDX_W'(1);
                     end
                  end else begin
                     if (sym_code == SYM_F) begin
                        mismatch_next = 1'b1;
                     end else begin
                        data_next[idx_reg[1:0]] = sym_code[0];
                     end
                     if (idx_reg == DATA_LAST) begin
                        idx_next   = '0;
                        state_next = SYNC_WAIT;
                     end else begin
                        idx_next = idx_reg + IDX_W'(1);
                     end
                  end
               end
            end

            SYNC_WAIT: begin
               if (is_sync) begin
                  state_next = CHECK;
               end else if (is_body) begin
                  err_next   = 1'b1;
                  run_next   = '0;
                  state_next = HUNT;
               end
            end

            CHECK: begin
               state_next    = ADDR;
               idx_next      = '0;
               mismatch_next = 1'b0;
               // A strobe here cannot be parsed; it is dropped and flagged.
               if (sym_valid) begin
                  err_next = 1'b1;
               end
               if (mismatch_reg) begin
                  err_next = 1'b1;
                  run_next = '0;
               end else if (data_reg == cand_reg) begin
                  if (run_reg != RUN_MAX) begin
                     run_next = run_inc;
                     if (run_inc == RUN_MAX) begin
                        dv_next = 1'b1;
                        d_next  = cand_reg;
                     end
                  end
               end else begin
                  cand_next = data_reg;
                  run_next  = RUN_ONE;
                  if (RUN_MAX == RUN_ONE) begin
                     dv_next = 1'b1;
                     d_next  = data_reg;
                  end
               end
            end

            default: begin
               state_next = HUNT;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge osc_clk or posedge reset) begin
      if (reset) begin
         state_reg    <= HUNT;
         idx_reg      <= '0;
         mismatch_reg <= 1'b0;
         run_reg      <= '0;
         cand_reg     <= '0;
         data_reg     <= '0;
         d_reg        <= '0;
         dv_reg       <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         idx_reg      <= idx_next;
         mismatch_reg <= mismatch_next;
         run_reg      <= run_next;
         cand_reg     <= cand_next;
         data_reg     <= data_next;
         d_reg        <= d_next;
         dv_reg       <= dv_next;
         err_reg      <= err_next;
      end
   end

   assign D    = d_reg;
   assign dv   = dv_reg;
   assign err  = err_reg;
   assign busy = (state_reg != HUNT);

endmodule

// File: tb/tb_pt2272_frame_controller.sv
// Bench for pt2272_frame_controller: directed frame scenarios plus random
// frames, checked against a symbol-position reference model.
module tb_pt2272_frame_controller;

   localparam int R  = 2;
   localparam int TO = 256;

   logic        osc_clk = 1'b0;
   logic        reset;
   logic        sym_valid;
   logic [1:0]  sym_code;
   logic [15:0] addr_code;
   logic [3:0]  D;
   logic        dv;
   logic        err;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: frame position 0..7 address, 8..11 data, 12 awaiting sync
   bit       m_in_frame;
   int       m_pos;
   bit       m_mm;
   bit [3:0] m_word;
   int       m_run;
   bit [3:0] m_cand;
   bit [3:0] m_d;

   // observation of the window following one strobe
   int w_k, w_err, w_dv, w_err_first, w_dv_first;
   int g_err = 0;
   int g_dv  = 0;
   int n_frames = 0;

   pt2272_frame_controller #(
      .REPEAT_COUNT (R),
      .TIMEOUT      (TO)
   ) dut (
      .osc_clk   (osc_clk),
      .reset     (reset),
      .sym_valid (sym_valid),
      .sym_code  (sym_code),
      .addr_code (addr_code),
      .D         (D),
      .dv        (dv),
      .err       (err),
      .busy      (busy)
   );

   always #5 osc_clk = ~osc_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_in_frame = 0; m_pos = 0; m_mm = 0; m_word = 0;
      m_run = 0; m_cand = 0; m_d = 0;
   endtask

   // Apply one symbol to the model; report expected err/dv pulses and err latency.
   task automatic model_step(input logic [1:0] c, output int e_err, output int e_dv, output int e_first);
      int pair;
      e_err = 0; e_dv = 0; e_first = 0;
      if (!m_in_frame) begin
         if (c == 2'b01) begin
            m_in_frame = 1; m_pos = 0; m_mm = 0;
         end
      end else if (c == 2'b01) begin
         if (m_pos < 12) begin
            e_err = 1; e_first = 1; m_run = 0;
         end else if (m_mm) begin
            e_err = 1; e_first = 2; m_run = 0;
         end else if (m_word == m_cand) begin
            if (m_run < R) begin
               m_run++;
               if (m_run == R) begin e_dv = 1; m_d = m_cand; end
            end
         end else begin
            m_cand = m_word; m_run = 1;
            if (R == 1) begin e_dv = 1; m_d = m_word; end
         end
         m_pos = 0; m_mm = 0;
      end else if (m_pos < 8) begin
         pair = int'((addr_code >> (2 * m_pos)) & 16'h3);
         if (pair == 1 || pair != int'(c)) m_mm = 1;
         m_pos++;
      end else if (m_pos < 12) begin
         if (c == 2'b10) m_mm = 1;
         else m_word[m_pos - 8] = c[0];
         m_pos++;
      end else begin
         e_err = 1; e_first = 1; m_run = 0; m_in_frame = 0;
      end
   endtask

   task automatic acc();
      w_k++;
      if (err) begin
         w_err++; g_err++;
         if (w_err_first == 0) w_err_first = w_k;
      end
      if (dv) begin
         w_dv++; g_dv++;
         if (w_dv_first == 0) w_dv_first = w_k;
      end
   endtask

   // Strobe one symbol (starting on a falling edge), then wait 'idle' cycles and check.
   task automatic send_sym(input logic [1:0] c, input int idle);
      int e_err, e_dv, e_first;
      model_step(c, e_err, e_dv, e_first);
      w_k = 0; w_err = 0; w_dv = 0; w_err_first = 0; w_dv_first = 0;
      sym_valid = 1'b1;
      sym_code  = c;
      @(negedge osc_clk);
      sym_valid = 1'b0;
      acc();
      repeat (idle) begin
         @(negedge osc_clk);
         acc();
      end
      if (m_in_frame && idle >= TO) begin
         if (e_err == 0) e_first = TO + 1;
         e_err++; m_run = 0; m_in_frame = 0;
      end
      check("err_count", w_err, e_err);
      check("dv_count", w_dv, e_dv);
      if (e_err > 0) check("err_latency", w_err_first, e_first);
      if (e_dv > 0) check("dv_latency", w_dv_first, 2);
      check("D_value", D, m_d);
      check("busy", busy, m_in_frame);
   endtask

   function automatic logic [1:0] body_sym(input logic [15:0] a, input logic [3:0] d, input int bad_idx, input int i);
      logic [1:0] s;
      if (i < 8) begin
         s = a[2*i +: 2];
         if (s == 2'b01) s = 2'b00;
      end else if (i - 8 == bad_idx) begin
         s = 2'b10;
      end else begin
         s = d[i-8] ? 2'b11 : 2'b00;
      end
      return s;
   endfunction

   task automatic send_frame(input logic [15:0] a, input logic [3:0] d, input int bad_idx,
                             input int n_body, input int long_at, input int long_idle, input logic [1:0] tail);
      for (int i = 0; i < n_body; i++) begin
         send_sym(body_sym(a, d, bad_idx, i), (i == long_at) ? long_idle : int'($urandom_range(1, 3)));
      end
      send_sym(tail, int'($urandom_range(2, 4)));
      n_frames++;
      $display("frame %0d: data=%b body=%0d tail=%b -> D=%b busy=%b errs=%0d dvs=%0d",
               n_frames, d, n_body, tail, D, busy, g_err, g_dv);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sym_valid = 1'b0;
      #1;
      check("reset_D", D, 0);
      check("reset_dv", dv, 0);
      check("reset_err", err, 0);
      check("reset_busy", busy, 0);
      repeat (2) @(negedge osc_clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL sim_timeout: got 1 expected 0");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      int g0;
      logic [15:0] a;
      logic [3:0] words [3];
      int kind, idx;
      words[0] = 4'h3; words[1] = 4'hA; words[2] = 4'h6;

      reset = 1'b1; sym_valid = 1'b0; sym_code = 2'b00; addr_code = 16'hF0A3;
      model_reset();
      repeat (3) @(negedge osc_clk);
      check("reset_D", D, 0);
      check("reset_dv", dv, 0);
      check("reset_err", err, 0);
      check("reset_busy", busy, 0);
      reset = 1'b0;
      @(negedge osc_clk);

      // two matching frames publish 0101
      send_sym(2'b01, 2);
      send_frame(16'hF0A3, 4'b0101, -1, 12, -1, 0, 2'b01);
      check("first_frame_no_dv", g_dv, 0);
      send_frame(16'hF0A3, 4'b0101, -1, 12, -1, 0, 2'b01);
      check("published_0101", D, 4'b0101);

      // candidate replacement then repeat; no errors
      g0 = g_err;
      send_frame(16'hF0A3, 4'b1010, -1, 12, -1, 0, 2'b01);
      send_frame(16'hF0A3, 4'b0011, -1, 12, -1, 0, 2'b01);
      send_frame(16'hF0A3, 4'b0011, -1, 12, -1, 0, 2'b01);
      check("published_0011", D, 4'b0011);
      check("no_err_pulses", g_err - g0, 0);

      // address mismatch at symbol 3 clears the run
      send_frame(16'hF0A3, 4'b0011, -1, 12, -1, 0, 2'b01);
      send_frame(16'hF0E3, 4'b0011, -1, 12, -1, 0, 2'b01);
      send_frame(16'hF0A3, 4'b1001, -1, 12, -1, 0, 2'b01);
      send_frame(16'hF0A3, 4'b1001, -1, 12, -1, 0, 2'b01);
      check("published_1001", D, 4'b1001);

      // F data symbol, then sync inside DATA
      send_frame(16'hF0A3, 4'b1001, 2, 12, -1, 0, 2'b01);
      send_frame(16'hF0A3, 4'b0110, -1, 10, -1, 0, 2'b01);
      send_frame(16'hF0A3, 4'b0110, -1, 12, 3, TO - 1, 2'b01);
      send_frame(16'hF0A3, 4'b0110, -1, 12, -1, 0, 2'b01);
      check("published_0110", D, 4'b0110);

      // watchdog expiry after address symbol 4, then a sync-less frame is ignored
      send_frame(16'hF0A3, 4'b0110, -1, 5, 4, TO, 2'b00);
      check("busy_after_timeout", busy, 0);
      g0 = g_err;
      send_frame(16'hF0A3, 4'b0110, -1, 12, -1, 0, 2'b01);
      check("ignored_frame_err", g_err - g0, 0);

      // reset mid-DATA after one valid frame
      send_frame(16'hF0A3, 4'b1100, -1, 12, -1, 0, 2'b01);
      for (int i = 0; i < 10; i++) send_sym(body_sym(16'hF0A3, 4'b1100, -1, i), 1);
      do_reset();
      send_sym(2'b01, 2);
      send_frame(16'hF0A3, 4'b1100, -1, 12, -1, 0, 2'b01);
      check("after_reset_D", D, 0);
      send_frame(16'hF0A3, 4'b1100, -1, 12, -1, 0, 2'b01);
      check("after_reset_published", D, 4'b1100);

      // random frames
      for (int f = 0; f < 80; f++) begin
         if ($urandom_range(0, 9) == 0) begin
            for (int p = 0; p < 8; p++) begin
               kind = int'($urandom_range(0, 15));
               addr_code[2*p +: 2] = (kind == 0) ? 2'b01 : (kind < 6) ? 2'b00 : (kind < 11) ? 2'b11 : 2'b10;
            end
         end
         if (!m_in_frame) send_sym(2'b01, int'($urandom_range(1, 3)));
         a = addr_code;
         kind = int'($urandom_range(0, 9));
         case (kind)
            0: begin
               idx = int'($urandom_range(0, 7));
               a[2*idx +: 2] = (a[2*idx +: 2] == 2'b00) ? 2'b11 : 2'b00;
               send_frame(a, words[$urandom_range(0, 2)], -1, 12, -1, 0, 2'b01);
            end
            1: send_frame(a, words[$urandom_range(0, 2)], int'($urandom_range(0, 3)), 12, -1, 0, 2'b01);
            2: send_frame(a, words[$urandom_range(0, 2)], -1, int'($urandom_range(0, 11)), -1, 0, 2'b01);
            3: send_frame(a, words[$urandom_range(0, 2)], -1, 12, -1, 0, 2'b11);
            4: send_frame(a, words[$urandom_range(0, 2)], -1, 12, int'($urandom_range(0, 11)),
                          int'($urandom_range(TO - 3, TO + 3)), 2'b01);
            default: send_frame(a, words[$urandom_range(0, 2)], -1, 12, -1, 0, 2'b01);
         endcase
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pt2272_frame_controller.md
PT2272_FRAME_CONTROLLER -- requirements
Module: pt2272_frame_controller

Interface
REQ-001 The block SHALL have parameter REPEAT_COUNT, default 2: number of consecutive identical valid frames needed to publish data (range 1..7).
REQ-002 The block SHALL have parameter TIMEOUT, default 256: osc_clk cycles without sym_valid that abort a frame in progress.
REQ-003 The block SHALL have port osc_clk, input, 1 bit: 12 kHz decoder clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port sym_valid, input, 1 bit: one-cycle strobe marking a classified symbol.
REQ-006 The block SHALL have port sym_code, input, 2 bits: symbol code, 00=bit0, 11=bit1, 10=F, 01=sync.
REQ-007 The block SHALL have port addr_code, input, 16 bits: local trinary address; pair [2i+1:2i] is the code for address symbol i (00/11/10).
REQ-008 The block SHALL have port D, output, 4 bits: published data word.
REQ-009 The block SHALL have port dv, output, 1 bit: one-cycle pulse when D updates.
REQ-010 The block SHALL have port err, output, 1 bit: one-cycle pulse per rejected or aborted frame.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not HUNT.

Function
REQ-012 The frame format SHALL be 8 address symbols (index 0 first), then 4 data symbols (D[0] first), then sync.
REQ-013 The FSM SHALL have states HUNT, ADDR, DATA, SYNC_WAIT and CHECK.
REQ-014 HUNT SHALL discard every symbol except sync; a sync SHALL move the FSM to ADDR with the symbol index at 0.
REQ-015 In ADDR, each symbol SHALL be compared with its addr_code pair; any difference, or an addr_code pair of 01, SHALL set a sticky mismatch flag; after index 7 the FSM SHALL go to DATA.
REQ-016 In DATA, symbol 00 or 11 SHALL store bit 0 or 1; symbol F SHALL set mismatch; after the 4th symbol the FSM SHALL go to SYNC_WAIT.
REQ-017 A sync received in ADDR or DATA SHALL pulse err, clear the mismatch flag and run count, and restart ADDR at index 0.
REQ-018 In SYNC_WAIT, a sync SHALL move the FSM to CHECK; any other symbol SHALL pulse err, clear the run count and move to HUNT.
REQ-019 CHECK SHALL last exactly one cycle, then go to ADDR at index 0 with mismatch cleared.
REQ-020 In CHECK, if mismatch is set: err pulses and the run count clears.
REQ-021 In CHECK, if mismatch is clear and the data equals the stored candidate: the run count increments, saturating at REPEAT_COUNT.
REQ-022 In CHECK, if mismatch is clear and the data differs from the candidate: the candidate is replaced by the new data and the run count is set to 1.
REQ-023 When the run count first reaches REPEAT_COUNT, D SHALL load the candidate and dv SHALL pulse; further identical frames SHALL NOT pulse dv.
REQ-024 D, dv and err SHALL be registered and visible the cycle after CHECK, i.e. 2 cycles after the sync strobe.
REQ-025 A sym_valid during CHECK SHALL be dropped and pulse err; the upstream guarantees no consecutive strobes.
REQ-026 The watchdog SHALL count cycles without sym_valid outside HUNT; at TIMEOUT it SHALL pulse err, clear the run count and go to HUNT.
REQ-027 If sym_valid coincides with the timeout cycle, the symbol SHALL win and the watchdog SHALL restart.
REQ-028 D SHALL hold its value between dv pulses.

Reset
REQ-029 On reset: state=HUNT, D=0, dv=0, err=0, busy=0, and index, mismatch, run count, candidate and watchdog all 0.
REQ-030 Reset asserted mid-frame SHALL abort immediately with no err or dv pulse.

Structure
REQ-031 Package pt2272_pkg SHALL hold the sym_code typedef (SYM_0, SYM_1, SYM_F, SYM_SYNC), the FSM state enum, and frame-length constants (8 address, 4 data).
REQ-032 The watchdog SHALL be the sub-module pt2272_sym_watchdog (inputs kick and enable; output expired; parameter TIMEOUT).

Verification
REQ-033 addr_code=16'hF0A3; sync, then two frames with address symbols 11,00,10,10,00,00,11,11 and data 1,0,1,0, each ending in sync -> no dv after frame 1; after frame 2, D=4'b0101 and dv high for 1 cycle, 2 cycles after the sync.
REQ-034 Frames with data 0101, then 1100, then 1100 -> single dv after frame 3 with D=4'b0011; err never pulses.
REQ-035 A valid frame, then a frame with address symbol 3 = 11 -> err pulse after the second sync, run count 0; a following valid frame gives no dv until a second valid frame.
REQ-036 F as data symbol 2 -> err pulse at CHECK, no dv; a sync arriving mid-DATA -> err, and the next frame is parsed from index 0.
REQ-037 256 idle cycles after address symbol 4 -> one err pulse, busy falls to 0; the next frame without a leading sync is ignored (no dv, no err).
REQ-038 Reset pulsed during DATA after one valid frame -> D=0, dv=0, busy=0; two further frames are needed for dv.
